sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single off-chip 16-bit asynchronous SRAM between three requesters in the 108 MHz domain: the display fetch (0), game logic (1) and asset loader (2). It grants one access per two clock cycles and sequences address, data, OE_N and WE_N for that access. Read data returns on a single shared return bus. The block sits between the game top and the SRAM pins.

## Interface
- `DISP_BURST_MAX`, default 4: maximum consecutive display grants while a requester 1/2 request is pending.
- `i_clk`  in  1  108 MHz system clock.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_req`  in  [3]  access request per requester; held until granted.
- `i_we`  in  [3]  1 = write. `i_we[0]` is ignored; the display port is read-only.
- `i_addr`  in  [3][20]  word address; stable while `i_req` is high.
- `i_wdata`  in  [3][16]  write data; stable while `i_req` is high.
- `o_gnt`  out  [3]  one-cycle pulse, one-hot; the request was accepted.
- `o_rvalid`  out  [3]  one-cycle pulse; `o_rdata` holds read data for that requester.
- `o_rdata`  out  16  registered read data, shared by all requesters.
- `o_SRAM_ADDR`  out  20  SRAM address.
- `io_SRAM_DQ`  inout  16  driven only during writes, otherwise Z.
- `o_SRAM_WE_N`  out  1  write strobe, active-low.
- `o_SRAM_OE_N`  out  1  output enable, active-low.

CE_N, LB_N and UB_N are tied low outside this block.

## Operation
States: IDLE, P0 (address phase), P1 (strobe/sample phase).

**Arbitration**
- Arbitration is evaluated in IDLE and in P1, which allows back-to-back accesses.
- A winner moves the FSM to P0; no request moves it to IDLE.
- Priority: requester 0 wins, unless the burst counter has reached `DISP_BURST_MAX` and `i_req[1]` or `i_req[2]` is high.
- Between requesters 1 and 2, a round-robin pointer picks. Reset value of the pointer is 1. After a grant to 1 or 2 the pointer moves to the other one.
- Burst counter, 3 bits:
  - increments on a display grant while a requester 1/2 request is pending;
  - clears on any requester 1/2 grant;
  - clears when no requester 1/2 request is pending.
- The winner's address, data and we are latched when it wins.

**Read access**
- P0: ADDR = latched address, OE_N = 0, WE_N = 1, DQ = Z.
- P1: same pin values. DQ is sampled into `o_rdata` at the end of P1.

**Write access**
- P0: ADDR driven, OE_N = 1, WE_N = 1, DQ driven with the latched data.
- P1: WE_N = 0, DQ still driven.
- The next cycle always has WE_N = 1. If the next access is a read, DQ = Z in its P0.

**Pin values in IDLE**
- ADDR holds its last value, OE_N = 1, WE_N = 1, DQ = Z.

**Reset values**
- State = IDLE, ADDR = 0, WE_N = 1, OE_N = 1, DQ = Z.
- `o_gnt` = 0, `o_rvalid` = 0, `o_rdata` = 0, burst counter = 0.

**Reset mid-access**
- WE_N and OE_N go high and DQ goes Z immediately.
- The access is dropped and no `o_rvalid` is produced.

## Timing
- Cycle n: requester k wins (FSM in IDLE or P1).
- Cycle n+1: P0; `o_gnt[k]` = 1.
- Cycle n+2: P1.
- Cycle n+3: for a read, `o_rvalid[k]` = 1 and `o_rdata` is valid. It may also be P0 of the next access.
- Requester handshake:
  - On seeing `o_gnt[k]` in cycle n+1, the requester deasserts or updates its request at the n+1/n+2 edge.
  - The arbiter next samples requests in cycle n+2, so a still-high request is a new request.
- Peak throughput: one access per 2 cycles (54 M words/s).
- Only one of `o_gnt` and one of `o_rvalid` can be high in any cycle.
- Requests raised in the P0 cycle are not seen until P1.
- Write-to-read turnaround needs no extra cycle.

## Structure
- `sram_pkg` holds:
  - SRAM_ADDR_W = 20, SRAM_DATA_W = 16, NUM_SRAM_REQ = 3;
  - REQ_DISP = 0, REQ_GAME = 1, REQ_LOAD = 2;
  - the state enum `sram_arb_state_e` (IDLE, P0, P1).
- Sub-module `sram_arb_pick` (combinational):
  - inputs: `i_req`, round-robin pointer, burst-limit flag;
  - output: one-hot winner.
- The FSM, latches, burst counter and pin drive live in `sram_arbiter`.

## Test plan
- **Reset:** assert `i_rst_n` = 0 with all requests high -> WE_N = 1, OE_N = 1, DQ = Z, `o_gnt` = 0.
- **Single read:** SRAM model holds 0x1234 at 0x00010; req0 read of 0x00010 in cycle n -> `o_gnt[0]` at n+1, OE_N = 0 in n+1 and n+2, `o_rvalid[0]` with `o_rdata` = 0x1234 at n+3.
- **Write then read-back:** req1 writes 0xBEEF to 0x00100; WE_N is low only in P1 and DQ = 0xBEEF in P0–P1; req1 then reads 0x00100 -> `o_rdata` = 0xBEEF.
- **Round-robin:** req1 and req2 held continuously, req0 idle -> grants alternate 1, 2, 1, 2 every 2 cycles, first grant to 1 after reset.
- **Starvation limit:** req0 and req2 held continuously, `DISP_BURST_MAX` = 4 -> grant pattern 0, 0, 0, 0, 2, 0, 0, 0, 0, 2.
- **Reset mid-write:** pull `i_rst_n` low during P1 of a write -> WE_N high in the same cycle, no `o_rvalid`; after release the FSM starts in IDLE.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and state type for the 108 MHz SRAM arbiter and its
// winner-select logic.
package sram_pkg;

    localparam int SRAM_ADDR_W  = 20;
    localparam int SRAM_DATA_W  = 16;
    localparam int NUM_SRAM_REQ = 3;

    localparam int REQ_DISP = 0;
    localparam int REQ_GAME = 1;
    localparam int REQ_LOAD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } sram_arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select: display first unless its burst limit is hit
// while game/loader wait; game and loader share a round-robin pointer.
module sram_arb_pick
    import sram_pkg::*;
(
    input  logic [NUM_SRAM_REQ-1:0] i_req,
    input  logic [1:0]              i_rr_ptr,
    input  logic                    i_burst_hit,
    output logic [NUM_SRAM_REQ-1:0] o_win
);

    logic others_pending;

    assign others_pending = i_req[REQ_GAME] | i_req[REQ_LOAD];

    always_comb begin
        o_win = '0;
        if (i_req[REQ_DISP] && !(i_burst_hit && others_pending)) begin
            o_win[REQ_DISP] = 1'b1;
        end else if (i_req[REQ_GAME] && (!i_req[REQ_LOAD] || i_rr_ptr == 2'(REQ_GAME))) begin
            o_win[REQ_GAME] = 1'b1;
        end else if (i_req[REQ_LOAD]) begin
            o_win[REQ_LOAD] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the off-chip async SRAM: one access per two cycles,
// address phase (P0) then strobe/sample phase (P1), shared read-return bus.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int DISP_BURST_MAX = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic [NUM_SRAM_REQ-1:0]                   i_req,
    input  logic [NUM_SRAM_REQ-1:0]                   i_we,
    input  logic [NUM_SRAM_REQ-1:0][SRAM_ADDR_W-1:0]  i_addr,
    input  logic [NUM_SRAM_REQ-1:0][SRAM_DATA_W-1:0]  i_wdata,
    output logic [NUM_SRAM_REQ-1:0]                   o_gnt,
    output logic [NUM_SRAM_REQ-1:0]                   o_rvalid,
    output logic [SRAM_DATA_W-1:0]                    o_rdata,
    output logic [SRAM_ADDR_W-1:0]                    o_SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0]                    io_SRAM_DQ,
    output logic                                      o_SRAM_WE_N,
    output logic                                      o_SRAM_OE_N,
    output sram_arb_state_e                           o_dbg_state
);

    // Handshake: i_req[k] is held (with stable addr/data/we) until o_gnt[k]
    // pulses; a request still high in the cycle after o_gnt is a new request.
    localparam logic [2:0] BURST_LIM = 3'(DISP_BURST_MAX);

    sram_arb_state_e          state_q;
    logic [SRAM_ADDR_W-1:0]   addr_q;
    logic [SRAM_DATA_W-1:0]   wdata_q;
    logic                     we_q;
    logic [NUM_SRAM_REQ-1:0]  sel_q;
    logic [2:0]               burst_cnt_q;
    logic [1:0]               rr_ptr_q;

    logic [NUM_SRAM_REQ-1:0]  win;
    logic                     burst_hit;
    logic                     others_pending;
    logic                     in_access;
    logic [SRAM_ADDR_W-1:0]   win_addr;
    logic [SRAM_DATA_W-1:0]   win_wdata;
    logic                     win_we;

    assign burst_hit      = burst_cnt_q >= BURST_LIM;
    assign others_pending = i_req[REQ_GAME] | i_req[REQ_LOAD];
    assign in_access      = (state_q == P0) || (state_q == P1);

    sram_arb_pick u_pick (
        .i_req       (i_req),
        .i_rr_ptr    (rr_ptr_q),
        .i_burst_hit (burst_hit),
        .o_win       (win)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        for (int k = 0; k < NUM_SRAM_REQ; k++) begin
            if (win[k]) begin
                win_addr  = win_addr | i_addr[k];
                win_wdata = win_wdata | i_wdata[k];
                win_we    = win_we | (i_we[k] && (k != REQ_DISP));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= 2'(REQ_GAME);
            o_gnt       <= '0;
            o_rvalid    <= '0;
            o_rdata     <= '0;
        end else begin
            o_gnt    <= '0;
            o_rvalid <= '0;
            if (state_q == P0) begin
                state_q <= P1;
            end else begin
                // IDLE and P1 both arbitrate; P1 also closes out a read.
                if (state_q == P1 && !we_q) begin
                    o_rdata  <= io_SRAM_DQ;
                    o_rvalid <= sel_q;
                end
                if (|win) begin
                    state_q <= P0;
                    addr_q  <= win_addr;
                    wdata_q <= win_wdata;
                    we_q    <= win_we;
                    sel_q   <= win;
                    o_gnt   <= win;
                end else begin
                    state_q <= IDLE;
                end
                if (win[REQ_GAME] || win[REQ_LOAD] || !others_pending) begin
                    burst_cnt_q <= '0;
                end else if (win[REQ_DISP]) begin
                    burst_cnt_q <= burst_cnt_q + 3'd1;
                end
                if (win[REQ_GAME]) begin
                    rr_ptr_q <= 2'(REQ_LOAD);
                end else if (win[REQ_LOAD]) begin
                    rr_ptr_q <= 2'(REQ_GAME);
                end
            end
        end
    end

    // Pins decode straight from state so an async reset releases them at once.
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_OE_N = !(in_access && !we_q);
    assign o_SRAM_WE_N = !(state_q == P1 && we_q);
    assign io_SRAM_DQ  = (in_access && we_q) ? wdata_q : {SRAM_DATA_W{1'bz}};
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural async SRAM model.
module tb_sram_arbiter;
  import sram_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [2:0][19:0]    addr;
  logic [2:0][15:0]    wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [15:0]         rdata;
  logic [19:0]         sram_addr;
  wire  [15:0]         sram_dq;
  logic                we_n;
  logic                oe_n;
  sram_arb_state_e     dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0] exp_q[$];
  logic [15:0] mem [0:1023];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  sram_arbiter #(.DISP_BURST_MAX(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_OE_N (oe_n),
    .o_dbg_state (dbg_state)
  );

  // async SRAM model: drives on read, captures while WE_N is low
  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!we_n) mem[sram_addr[9:0]] <= sram_dq;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic single_access(input int k, input logic w, input logic [19:0] a,
                               input logic [15:0] d, input logic [15:0] exp_rd);
    logic [2:0] exp_g;
    logic [2:0] exp_rv;
    exp_g = '0;
    exp_g[k] = 1'b1;
    exp_rv = '0;
    if (!w) exp_rv[k] = 1'b1;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    check_eq("gnt_n", gnt, 0);
    @(posedge clk); #1;
    req[k] = 1'b0;
    @(negedge clk);
    check_eq("gnt_p0", gnt, exp_g);
    check_eq("addr_p0", sram_addr, a);
    check_eq("oe_p0", oe_n, w ? 1 : 0);
    check_eq("we_p0", we_n, 1);
    if (w) check_eq("dq_p0", sram_dq, d);
    @(negedge clk);
    check_eq("gnt_p1", gnt, 0);
    check_eq("oe_p1", oe_n, w ? 1 : 0);
    check_eq("we_p1", we_n, w ? 0 : 1);
    if (w) check_eq("dq_p1", sram_dq, d);
    @(negedge clk);
    check_eq("we_after", we_n, 1);
    check_eq("rvalid", rvalid, exp_rv);
    if (!w) check_eq("rdata", rdata, exp_rd);
  endtask

  // scoreboard: per-cycle expected o_gnt
  task automatic run_sched(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq("sched_underflow", 1, 0);
      end else begin
        check_eq("sched_gnt", gnt, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h010] = 16'h1234;
    rst_n = 1'b0;
    req   = 3'b111;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;

    // reset with every request high
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_we_n", we_n, 1);
    check_eq("rst_oe_n", oe_n, 1);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_state", dbg_state, IDLE);
    req = 3'b000;
    @(posedge clk); #1 rst_n = 1'b1;

    // single read, write, read-back
    single_access(0, 1'b0, 20'h00010, 16'h0000, 16'h1234);
    single_access(1, 1'b1, 20'h00100, 16'hBEEF, 16'h0000);
    single_access(1, 1'b0, 20'h00100, 16'h0000, 16'hBEEF);

    // write then back-to-back read of the same word
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 20'h00200; wdata[1] = 16'hCAFE;
    @(posedge clk); #1;
    we[1] = 1'b0;
    @(negedge clk);
    check_eq("b2b_gnt_wr", gnt, 3'b010);
    @(negedge clk);
    check_eq("b2b_we_p1", we_n, 0);
    check_eq("b2b_dq_p1", sram_dq, 16'hCAFE);
    @(negedge clk);
    check_eq("b2b_gnt_rd", gnt, 3'b010);
    check_eq("b2b_we_rd", we_n, 1);
    check_eq("b2b_oe_rd", oe_n, 0);
    check_eq("b2b_state", dbg_state, P0);
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b_rvalid", rvalid, 3'b010);
    check_eq("b2b_rdata", rdata, 16'hCAFE);

    // round-robin between game and loader, fresh pointer
    req = 3'b000;
    apply_reset();
    @(posedge clk); #1;
    req = 3'b110;
    exp_q = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100};
    run_sched(8);
    req = 3'b000;
    repeat (3) @(negedge clk);
    check_eq("rr_idle", dbg_state, IDLE);

    // display burst limit against a waiting loader
    @(posedge clk); #1;
    req = 3'b101;
    addr[0] = 20'h00010;
    addr[2] = 20'h00100;
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
      end
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b100);
    end
    run_sched(20);
    req = 3'b000;
    repeat (3) @(negedge clk);
    check_eq("burst_idle", dbg_state, IDLE);

    // reset during the strobe phase of a write
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 20'h00300; wdata[1] = 16'h5555;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_we_low", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_we_rel", we_n, 1);
    check_eq("mid_oe_rel", oe_n, 1);
    check_eq("mid_state", dbg_state, IDLE);
    @(negedge clk);
    check_eq("mid_rvalid0", rvalid, 0);
    @(posedge clk); #1;
    check_eq("mid_rvalid1", rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_state", dbg_state, IDLE);
    check_eq("post_gnt", gnt, 0);
    single_access(0, 1'b0, 20'h00100, 16'h0000, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
